alu_sequencer: RTL

//   Initiator side of the calculator ALU interface. Accepts one operation command over a

---
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Command, ALU and result signals between the calculator control logic, the sequencer and the ALU.
// CALC_ACCUM_EN adds cmd_use_acc to the command group.
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
`ifdef CALC_ACCUM_EN
  logic             cmd_use_acc;
`endif
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_err;

  modport master (
`ifdef CALC_ACCUM_EN
    input  cmd_use_acc,
`endif
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, res_ready,
    output cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_zero, res_err
  );

  modport slave (
`ifdef CALC_ACCUM_EN
    output cmd_use_acc,
`endif
    output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, res_ready,
    input  cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_zero, res_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-command sequencer in front of a combinational ALU: accept, execute one cycle, hold result.
// Optional feature macro CALC_ACCUM_EN: operand a may come from an accumulator of the last result.
module alu_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 4,
  parameter int OP_DIV = 11,
  parameter int OP_MAX = 11
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_err_q, res_err_d;
  logic             cmd_ready_c;
  logic             res_valid_c;
  logic             err_c;
  logic [WIDTH-1:0] opnd_a_c;

  function automatic logic op_error(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] b);
    return ((sel == SEL_W'(OP_DIV)) && (b == '0)) || (sel > SEL_W'(OP_MAX));
  endfunction

`ifdef CALC_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  assign opnd_a_c = bus.cmd_use_acc ? acc_q : bus.cmd_a;
`else
  assign opnd_a_c = bus.cmd_a;
`endif

  always_comb begin
    state_d     = state_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    err_c       = 1'b0;
`ifdef CALC_ACCUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          alu_sel_d = bus.cmd_sel;
          alu_a_d   = opnd_a_c;
          alu_b_d   = bus.cmd_b;
          state_d   = EXEC;
        end
      end
      // Capture stage: an error result is forced to zero so an undefined divide never escapes.
      EXEC: begin
        err_c      = op_error(alu_sel_q, alu_b_q);
        res_err_d  = err_c;
        res_data_d = err_c ? '0 : bus.alu_y;
        res_zero_d = err_c || (bus.alu_y == '0);
`ifdef CALC_ACCUM_EN
        acc_d      = err_c ? '0 : bus.alu_y;
`endif
        state_d    = DONE;
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
`ifdef CALC_ACCUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
`ifdef CALC_ACCUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_err   = res_err_q;

endmodule
